// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for the FIFO write arbiter.
// Master drives the requests and FIFO status. Slave is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          fifo_full;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          fifo_wdata_valid;

    modport master (
        output req,
        output req_data,
        output fifo_full,
        input  req_ack,
        input  fifo_write_data,
        input  fifo_wdata_valid
    );

    modport slave (
        input  req,
        input  req_data,
        input  fifo_full,
        output req_ack,
        output fifo_write_data,
        output fifo_wdata_valid
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// One producer streams up to BURST_LEN beats per grant.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    fifo_write_arbiter_if.slave  bus,
    output logic [IDX_WIDTH-1:0] grant_id,
    output logic                 busy
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               r_state;
    logic [IDX_WIDTH-1:0] r_grant;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_busy;

    logic                  w_found;
    logic [IDX_WIDTH-1:0]  w_next;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic                  w_sel_req;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_sel_req = bus.req[r_grant];
    assign w_accept  = (r_state == XFER) & w_sel_req
                     & ~bus.fifo_full & ~flush;
    assign w_last    = (r_cnt == CNT_WIDTH'(BURST_LEN - 1));

    // Round-robin search starting just after the last grant
    always_comb begin
        w_found = 1'b0;
        w_next  = r_grant;
        w_idx   = r_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_WIDTH'((int'(r_grant) + k) % NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    // Select the granted producer's data slice
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_WIDTH'(i) == r_grant) begin
                w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Steer the granted producer onto the FIFO write port
    always_comb begin
        bus.req_ack          = '0;
        bus.fifo_wdata_valid = w_accept;
        bus.fifo_write_data  = (r_state == XFER) ? w_data : '0;
        if (w_accept) begin
            bus.req_ack[r_grant] = 1'b1;
        end
    end

    // Arbitration / burst FSM with registered grant and busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= IDX_WIDTH'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!flush && w_found && !bus.fifo_full) begin
                        r_grant <= w_next;
                        r_cnt   <= '0;
                        r_state <= XFER;
                        r_busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_accept && w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end else if (!w_sel_req) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one sync FIFO write port among NUM_REQ producers.
- Arbitrates round-robin and grants one producer at a time for a burst of up to BURST_LEN beats.
- Steers the granted producer's data and valid onto the FIFO write_data/wdata_valid inputs, stalling on fifo_full.
- Sits directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of producers (2..16)
- IDX_WIDTH, 2, width of grant index; must satisfy 2**IDX_WIDTH >= NUM_REQ
- DATA_WIDTH, 16, FIFO data width
- BURST_LEN, 4, maximum accepted beats per grant (>=1)
- CNT_WIDTH, 3, burst counter width; must satisfy 2**CNT_WIDTH > BURST_LEN

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of current grant
- req  in  NUM_REQ  per-producer write request; bit i means producer i has a valid beat
- req_data  in  NUM_REQ*DATA_WIDTH  producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ack  out  NUM_REQ  one-hot beat accept; producer presents its next beat the following cycle
- fifo_full  in  1  from FIFO
- fifo_write_data  out  DATA_WIDTH  to FIFO write_data
- fifo_wdata_valid  out  1  to FIFO wdata_valid
- grant_id  out  IDX_WIDTH  index of current or most recent grant
- busy  out  1  high in XFER state

Behaviour:
- FSM states:
  - IDLE: arbitration cycle.
  - XFER: granted producer streaming.
- Reset values (asynchronous): state=IDLE, grant_id=NUM_REQ-1 (so producer 0 wins first), burst_cnt=0, busy=0. All combinational outputs are 0 in IDLE.
- IDLE transitions:
  - If flush=1: stay in IDLE.
  - Else if any req bit is set and fifo_full=0: pick the first set bit searching grant_id+1, grant_id+2, … with wrap modulo NUM_REQ (grant_id itself is checked last). Register it into grant_id, clear burst_cnt, go to XFER.
  - Else: stay in IDLE; grant_id holds.
- XFER outputs (combinational from registered state):
  - accept = req[grant_id] & ~fifo_full
  - fifo_wdata_valid = accept
  - fifo_write_data = req_data slice for grant_id; it is driven whenever in XFER, regardless of accept
  - req_ack[grant_id] = accept; all other req_ack bits are 0
- XFER transitions, priority order:
  1. flush=1: go to IDLE, no beat accepted (accept forced to 0), burst_cnt cleared.
  2. accept and burst_cnt==BURST_LEN-1: go to IDLE.
  3. accept: burst_cnt+1, stay in XFER.
  4. req[grant_id]==0: go to IDLE (producer released grant).
  5. fifo_full=1 with req held: stall in XFER, burst_cnt holds, no ack.
- Latency and throughput:
  - One IDLE cycle between request and first beat.
  - One bubble cycle between consecutive grants.
  - Within a grant, one beat per clock when not full.
- Fairness: a producer requesting continuously waits at most (NUM_REQ-1) bursts plus bubbles.
- fifo_full rising in the same cycle as a beat: that beat is not accepted (accept uses the current-cycle fifo_full).
- Reset mid-burst: immediate return to IDLE, with outputs as above. The FIFO is reset separately.
- Never more than one req_ack bit set; fifo_wdata_valid==|req_ack at all times.

Test Plan:
- Reset with req=4'b1111 held → all outputs 0, busy=0 while reset=1. On release: IDLE 1 cycle, then grant_id=0, busy=1, req_ack=4'b0001.
- BURST_LEN=4, only req[2] held for 6 beats (data 0x10..0x15) → beats 0x10–0x13 acked on consecutive cycles, 1 IDLE cycle, then 0x14–0x15 acked. FIFO receives 6 words in order.
- req=4'b1111 held continuously → grant_id sequence 0,1,2,3,0. Each grant accepts exactly 4 beats, with 1 bubble between grants.
- Producer 1 granted; fifo_full=1 for 3 cycles after its 2nd beat → fifo_wdata_valid=0, req_ack=0, burst_cnt holds at 2. Then 2 more beats are accepted and the grant ends.
- Producer 3 drops req after 1 beat while req[0]=1 → return to IDLE, then grant_id=0 (wrap-around search).
- flush=1 mid-burst with req still high → no ack that cycle, IDLE next cycle. Asserting reset mid-burst → busy=0, grant_id=NUM_REQ-1 asynchronously.
